// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and byte helpers for the HD44780 16x2 row writer.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ROW0     = 8'h80;
    localparam logic [7:0] LCD_ROW1     = 8'hC0;
    localparam logic [7:0] LCD_SPACE    = 8'h20;

    typedef enum logic [3:0] {
        ST_POWERUP,
        ST_INIT,
        ST_SNAP,
        ST_ADDR_TOP,
        ST_WR_TOP,
        ST_ADDR_BOT,
        ST_WR_BOT,
        ST_DONE,
        ST_IDLE
    } lcd_state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = LCD_FUNC_SET;
            2'd1:    cmd = LCD_DISP_ON;
            2'd2:    cmd = LCD_ENTRY;
            default: cmd = LCD_CLEAR;
        endcase
        return cmd;
    endfunction

    // NUL in a row image shows as a blank rather than the CGRAM glyph 0.
    function automatic logic [7:0] map_char(input logic [7:0] c);
        return (c == 8'h00) ? LCD_SPACE : c;
    endfunction

endpackage

// File: rtl/lcd1602_writer_if.sv
// Parallel HD44780 write bus: the writer drives it (master), the panel model/pins observe it (slave).
interface lcd1602_writer_if;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    modport master (output lcd_en, output lcd_rs, output lcd_rw, output lcd_data);
    modport slave  (input  lcd_en, input  lcd_rs, input  lcd_rw, input  lcd_data);
endinterface

// File: rtl/lcd_byte_strobe.sv
// One LCD byte write: latch rs/data, hold lcd_en high for EN_CYCLES, then wait before pulsing done.
module lcd_byte_strobe #(
    parameter int EN_CYCLES         = 10,
    parameter int WAIT_CYCLES       = 500,
    parameter int CLEAR_WAIT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       done
);

    localparam logic [31:0] EN_LEN     = 32'(EN_CYCLES);
    localparam logic [31:0] SHORT_LAST = 32'(EN_CYCLES + WAIT_CYCLES - 1);
    localparam logic [31:0] LONG_LAST  = 32'(EN_CYCLES + CLEAR_WAIT_CYCLES - 1);

    logic        active_q, active_d;
    logic [31:0] cnt_q, cnt_d;
    logic        long_q, long_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic        en_q, en_d;
    logic [31:0] last_cnt;

    // cnt counts cycles after the latch cycle, so done lands on the final cycle of the transfer.
    assign last_cnt = long_q ? LONG_LAST : SHORT_LAST;
    assign done     = active_q && (cnt_q == last_cnt);

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        long_d   = long_q;
        rs_d     = rs_q;
        data_d   = data_q;
        if (!active_q) begin
            if (start) begin
                active_d = 1'b1;
                cnt_d    = '0;
                rs_d     = rs;
                data_d   = data;
                long_d   = long_wait;
            end
        end else if (done) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
        en_d = active_d && (cnt_d < EN_LEN);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            long_q   <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            en_q     <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            long_q   <= long_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            en_q     <= en_d;
        end
    end

    assign lcd_en   = en_q;
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;

endmodule

// File: rtl/lcd1602_writer.sv
// Powers up and initialises a 16x2 HD44780 panel, then rewrites both rows whenever the row images change.
module lcd1602_writer
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYCLES    = 500000,
    parameter int EN_CYCLES         = 10,
    parameter int WAIT_CYCLES       = 500,
    parameter int CLEAR_WAIT_CYCLES = 20000
) (
    input  logic            clk,
    input  logic            nRst,
    input  logic [127:0]    top,
    input  logic [127:0]    bottom,
    output logic            busy,
    output logic            frame_done,
    lcd1602_writer_if.master lcd
);

    localparam logic [31:0] POWER_LEN = 32'(POWERUP_CYCLES);
    localparam logic [255:0] BLANK_ROWS = {32{LCD_SPACE}};

    lcd_state_t     state_q, state_d;
    logic [31:0]    pwr_cnt_q, pwr_cnt_d;
    logic [3:0]     idx_q, idx_d;
    logic           sent_q, sent_d;
    logic [127:0]   snap_top_q, snap_top_d;
    logic [127:0]   snap_bot_q, snap_bot_d;
    logic [255:0]   shadow_q, shadow_d;

    logic           start;
    logic           tx_rs;
    logic [7:0]     tx_data;
    logic           tx_long;
    logic           strb_done;
    logic           strb_en, strb_rs;
    logic [7:0]     strb_data;

    logic [7:0]     top_char [16];
    logic [7:0]     bot_char [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_col
        assign top_char[gi] = snap_top_q[127 - 8*gi -: 8];
        assign bot_char[gi] = snap_bot_q[127 - 8*gi -: 8];
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= ST_POWERUP;
            pwr_cnt_q  <= '0;
            idx_q      <= '0;
            sent_q     <= 1'b0;
            snap_top_q <= BLANK_ROWS[255:128];
            snap_bot_q <= BLANK_ROWS[127:0];
            shadow_q   <= BLANK_ROWS;
        end else begin
            state_q    <= state_d;
            pwr_cnt_q  <= pwr_cnt_d;
            idx_q      <= idx_d;
            sent_q     <= sent_d;
            snap_top_q <= snap_top_d;
            snap_bot_q <= snap_bot_d;
            shadow_q   <= shadow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pwr_cnt_d  = pwr_cnt_q;
        idx_d      = idx_q;
        snap_top_d = snap_top_q;
        snap_bot_d = snap_bot_q;
        shadow_d   = shadow_q;
        // sent marks a byte already handed to the strobe, so start fires once per byte.
        sent_d     = strb_done ? 1'b0 : (start ? 1'b1 : sent_q);
        case (state_q)
            ST_POWERUP: begin
                if (pwr_cnt_q + 32'd1 >= POWER_LEN) begin
                    state_d   = ST_INIT;
                    pwr_cnt_d = '0;
                    idx_d     = '0;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 32'd1;
                end
            end
            ST_INIT: begin
                if (strb_done) begin
                    if (idx_q == 4'd3) begin
                        state_d = ST_SNAP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_SNAP: begin
                snap_top_d = top;
                snap_bot_d = bottom;
                state_d    = ST_ADDR_TOP;
            end
            ST_ADDR_TOP: begin
                if (strb_done) begin
                    state_d = ST_WR_TOP;
                    idx_d   = '0;
                end
            end
            ST_WR_TOP: begin
                if (strb_done) begin
                    if (idx_q == 4'd15) begin
                        state_d = ST_ADDR_BOT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_ADDR_BOT: begin
                if (strb_done) begin
                    state_d = ST_WR_BOT;
                    idx_d   = '0;
                end
            end
            ST_WR_BOT: begin
                if (strb_done) begin
                    if (idx_q == 4'd15) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                shadow_d = {snap_top_q, snap_bot_q};
                state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                if ({top, bottom} != shadow_q) begin
                    state_d = ST_SNAP;
                end
            end
            default: state_d = ST_POWERUP;
        endcase
    end

    always_comb begin
        tx_rs      = 1'b0;
        tx_data    = 8'h00;
        start      = 1'b0;
        busy       = (state_q != ST_IDLE);
        frame_done = (state_q == ST_DONE);
        case (state_q)
            ST_INIT: begin
                tx_data = init_cmd(idx_q[1:0]);
                start   = !sent_q;
            end
            ST_ADDR_TOP: begin
                tx_data = LCD_ROW0;
                start   = !sent_q;
            end
            ST_WR_TOP: begin
                tx_rs   = 1'b1;
                tx_data = map_char(top_char[idx_q]);
                start   = !sent_q;
            end
            ST_ADDR_BOT: begin
                tx_data = LCD_ROW1;
                start   = !sent_q;
            end
            ST_WR_BOT: begin
                tx_rs   = 1'b1;
                tx_data = map_char(bot_char[idx_q]);
                start   = !sent_q;
            end
            default: begin
                tx_rs   = 1'b0;
                tx_data = 8'h00;
            end
        endcase
        tx_long = !tx_rs && (tx_data == LCD_CLEAR);
    end

    lcd_byte_strobe #(
        .EN_CYCLES         (EN_CYCLES),
        .WAIT_CYCLES       (WAIT_CYCLES),
        .CLEAR_WAIT_CYCLES (CLEAR_WAIT_CYCLES)
    ) u_strobe (
        .clk       (clk),
        .nRst      (nRst),
        .start     (start),
        .rs        (tx_rs),
        .data      (tx_data),
        .long_wait (tx_long),
        .lcd_en    (strb_en),
        .lcd_rs    (strb_rs),
        .lcd_data  (strb_data),
        .done      (strb_done)
    );

    assign lcd.lcd_en   = strb_en;
    assign lcd.lcd_rs   = strb_rs;
    assign lcd.lcd_rw   = 1'b0;
    assign lcd.lcd_data = strb_data;

endmodule

// File: tb/tb_lcd1602_writer.sv
// Bench for lcd1602_writer: a transfer-level timeline model predicts every output on every cycle.
module tb_lcd1602_writer;

    localparam int P    = 20;
    localparam int EN   = 2;
    localparam int WT   = 3;
    localparam int CW   = 10;
    localparam int MAXC = 12000;
    localparam int INF  = 1 << 30;

    logic         clk = 1'b0;
    logic         nRst = 1'b0;
    logic [127:0] top;
    logic [127:0] bottom;
    logic         busy;
    logic         frame_done;

    lcd1602_writer_if lcd();

    lcd1602_writer #(
        .POWERUP_CYCLES    (P),
        .EN_CYCLES         (EN),
        .WAIT_CYCLES       (WT),
        .CLEAR_WAIT_CYCLES (CW)
    ) dut (
        .clk        (clk),
        .nRst       (nRst),
        .top        (top),
        .bottom     (bottom),
        .busy       (busy),
        .frame_done (frame_done),
        .lcd        (lcd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outputs per cycle, filled ahead of time from transfer lengths.
    logic       e_en   [MAXC];
    logic       e_rs   [MAXC];
    logic [7:0] e_data [MAXC];
    logic       e_busy [MAXC];
    logic       e_fd   [MAXC];

    int           rel_cyc   = 0;
    int           snap_at   = -1;
    int           idle_from = INF;
    bit           in_reset  = 1'b1;
    logic         m_rs      = 1'b0;
    logic [7:0]   m_data    = 8'h00;
    logic [255:0] shadow_m  = '0;

    logic [8:0] xlog [$];
    int         fd_cyc [$];
    int         fd_cnt   = 0;
    int         en_rises = 0;
    logic       en_prev  = 1'b0;

    task automatic put(input int c, input bit en, input bit b, input bit fd);
        if (c < MAXC) begin
            e_en[c]   = en;
            e_rs[c]   = m_rs;
            e_data[c] = m_data;
            e_busy[c] = b;
            e_fd[c]   = fd;
        end
    endtask

    // One byte: latch cycle shows the previous byte, then EN high cycles, then the wait.
    task automatic xfer(input int t0, input bit rs, input logic [7:0] d, output int t1);
        logic [7:0] dm;
        int len;
        dm  = (d == 8'h00) ? 8'h20 : d;
        len = 1 + EN + ((!rs && dm == 8'h01) ? CW : WT);
        put(t0, 1'b0, 1'b1, 1'b0);
        m_rs   = rs;
        m_data = dm;
        for (int i = 1; i < len; i++) put(t0 + i, (i <= EN), 1'b1, 1'b0);
        t1 = t0 + len;
    endtask

    always @(negedge clk) begin
        int t;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d, expected below %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        if (!nRst) begin
            in_reset  = 1'b1;
            m_rs      = 1'b0;
            m_data    = 8'h00;
            snap_at   = -1;
            idle_from = INF;
            chk("rst_en",   32'(lcd.lcd_en),   32'd0);
            chk("rst_rs",   32'(lcd.lcd_rs),   32'd0);
            chk("rst_rw",   32'(lcd.lcd_rw),   32'd0);
            chk("rst_data", 32'(lcd.lcd_data), 32'd0);
            chk("rst_busy", 32'(busy),         32'd1);
            chk("rst_fd",   32'(frame_done),   32'd0);
        end else begin
            if (in_reset) begin
                in_reset = 1'b0;
                rel_cyc  = cyc;
                for (int i = 0; i < P; i++) put(cyc + i, 1'b0, 1'b1, 1'b0);
                t = cyc + P;
                xfer(t, 1'b0, 8'h38, t);
                xfer(t, 1'b0, 8'h0C, t);
                xfer(t, 1'b0, 8'h06, t);
                xfer(t, 1'b0, 8'h01, t);
                snap_at = t;
            end
            if (cyc == snap_at) begin
                put(cyc, 1'b0, 1'b1, 1'b0);
                t = cyc + 1;
                xfer(t, 1'b0, 8'h80, t);
                for (int i = 0; i < 16; i++) xfer(t, 1'b1, top[127 - 8*i -: 8], t);
                xfer(t, 1'b0, 8'hC0, t);
                for (int i = 0; i < 16; i++) xfer(t, 1'b1, bottom[127 - 8*i -: 8], t);
                put(t, 1'b0, 1'b1, 1'b1);
                shadow_m  = {top, bottom};
                idle_from = t + 1;
                snap_at   = -1;
            end else if (cyc >= idle_from) begin
                put(cyc, 1'b0, 1'b0, 1'b0);
                if ({top, bottom} !== shadow_m) begin
                    snap_at   = cyc + 1;
                    idle_from = INF;
                end
            end
            chk("en",   32'(lcd.lcd_en),   32'(e_en[cyc]));
            chk("rs",   32'(lcd.lcd_rs),   32'(e_rs[cyc]));
            chk("rw",   32'(lcd.lcd_rw),   32'd0);
            chk("data", 32'(lcd.lcd_data), 32'(e_data[cyc]));
            chk("busy", 32'(busy),         32'(e_busy[cyc]));
            chk("fd",   32'(frame_done),   32'(e_fd[cyc]));
            if (lcd.lcd_en && !en_prev) begin
                xlog.push_back({lcd.lcd_rs, lcd.lcd_data});
                en_rises++;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc.push_back(cyc);
            end
        end
        en_prev = lcd.lcd_en;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_fd(input int target, input int budget, input string name);
        int n = 0;
        while (fd_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        chk(name, 32'(fd_cnt >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        int quiet = 0;
        step(2);
        while (quiet < 3 && n < budget) begin
            step(1);
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        chk(name, 32'(quiet >= 3), 32'd1);
    endtask

    function automatic logic [127:0] rand_row();
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(32, 126));
        return r;
    endfunction

    initial begin
        int n;
        int r0;
        top    = {16'h2020, "Win", 88'h0};
        bottom = {"APPLE", 88'h0};
        nRst   = 1'b0;
        step(3);
        nRst = 1'b1;

        // Power-up, init and the unconditional first frame.
        wait_fd(1, 400, "t1_frame_seen");
        chk("t1_fd_latency", 32'(fd_cyc[0] - rel_cyc), 32'd256);
        chk("t1_strobes",    32'(xlog.size()), 32'd38);
        chk("t1_init0", 32'(xlog[0]),  32'h038);
        chk("t1_init1", 32'(xlog[1]),  32'h00C);
        chk("t1_init2", 32'(xlog[2]),  32'h006);
        chk("t1_init3", 32'(xlog[3]),  32'h001);
        chk("t1_row0",  32'(xlog[4]),  32'h080);
        chk("t1_col1",  32'(xlog[6]),  32'h120);
        chk("t1_col2",  32'(xlog[7]),  32'h157);
        chk("t1_col5",  32'(xlog[10]), 32'h120);
        chk("t1_row1",  32'(xlog[21]), 32'h0C0);
        chk("t1_bcol0", 32'(xlog[22]), 32'h141);
        chk("t1_bcol5", 32'(xlog[27]), 32'h120);
        chk("t1_busy_after_done", 32'(busy), 32'd0);

        // Stable inputs: panel left alone.
        r0 = en_rises;
        step(1000);
        chk("t3_no_strobes", 32'(en_rises - r0), 32'd0);
        chk("t3_busy",       32'(busy), 32'd0);

        // Single-column change rewrites the whole frame.
        xlog.delete();
        n = fd_cnt;
        top[103:96] = 8'h41;
        wait_fd(n + 1, 400, "t4_frame_seen");
        chk("t4_strobes", 32'(xlog.size()), 32'd34);
        chk("t4_row0",    32'(xlog[0]), 32'h080);
        chk("t4_col3",    32'(xlog[4]), 32'h141);

        // Bottom change mid-frame is deferred to a back-to-back second frame.
        step(3);
        xlog.delete();
        n = fd_cnt;
        top[7:0] = 8'h33;
        step(40);
        bottom = {"PEAR", 96'h0};
        wait_fd(n + 2, 800, "t5_two_frames");
        chk("t5_gap",       32'(fd_cyc[n + 1] - fd_cyc[n]), 32'd207);
        chk("t5_old_bcol0", 32'(xlog[18]), 32'h141);
        chk("t5_new_bcol0", 32'(xlog[34 + 18]), 32'h150);

        // Randomised rows, half of them with a bottom change mid-frame.
        for (int k = 0; k < 6; k++) begin
            step(2);
            top    = rand_row();
            bottom = rand_row();
            if (k % 2 == 1) begin
                step(60);
                bottom = rand_row();
            end
            wait_idle(1500, "rnd_settle");
        end

        // Reset during WR_BOT restarts power-up and init.
        step(2);
        top = rand_row();
        step(150);
        nRst = 1'b0;
        step(2);
        xlog.delete();
        n = fd_cnt;
        nRst = 1'b1;
        wait_fd(n + 1, 400, "t6_frame_seen");
        chk("t6_fd_latency", 32'(fd_cyc[n] - rel_cyc), 32'd256);
        chk("t6_strobes",    32'(xlog.size()), 32'd38);
        chk("t6_init0",      32'(xlog[0]), 32'h038);
        chk("t6_init3",      32'(xlog[3]), 32'h001);

        step(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd1602_writer.md
Name: lcd1602_writer

Overview:
- Downstream consumer of the host display stage. Takes the 16-character top and bottom row images (ASCII, 128 bits each) and drives a HD44780-compatible 16x2 LCD over an 8-bit parallel bus.
- Runs the power-up and initialisation sequence once.
- Then rewrites both rows whenever either row image differs from what was last written to the panel.

Parameters:
- POWERUP_CYCLES, 500000: clk cycles to wait after reset before the first command (50 ms at 10 MHz).
- EN_CYCLES, 10: clk cycles lcd_en is held high per byte.
- WAIT_CYCLES, 500: clk cycles after lcd_en falls before the next byte may start.
- CLEAR_WAIT_CYCLES, 20000: replaces WAIT_CYCLES after the clear-display command (0x01).

Ports:
- clk  input  1  system clock
- nRst  input  1  asynchronous active-low reset
- top  input  128  top row; top[127:120] = column 0, top[7:0] = column 15
- bottom  input  128  bottom row; same byte order
- lcd_en  output  1  LCD enable strobe
- lcd_rs  output  1  0 = command, 1 = data
- lcd_rw  output  1  tied 0 (write only)
- lcd_data  output  8  LCD data bus
- busy  output  1  high while powering up, initialising or writing a frame
- frame_done  output  1  one-cycle pulse when the last bottom-row character completes

Behaviour:
- Reset: clk is the clock; nRst is asynchronous and active-low. While in reset, and immediately after it:
  - lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, frame_done=0, busy=1.
  - State POWERUP, counters 0, shadow rows all 8'h20.
  - Reset mid-frame aborts immediately; the full power-up and initialisation sequence reruns.
- Byte transfer, performed by the sub-module, starting on the cycle `start` is sampled high:
  - Cycle 0: latch rs/data onto lcd_rs/lcd_data, lcd_en=0.
  - Cycles 1..EN_CYCLES: lcd_en=1.
  - Next WAIT_CYCLES cycles (CLEAR_WAIT_CYCLES if the command is 0x01): lcd_en=0, data held.
  - Final wait cycle: `done` pulses.
  - Total length = 1+EN_CYCLES+wait. lcd_data/lcd_rs are stable for the whole transfer.
- Character mapping: a byte of 8'h00 is sent as 8'h20 (space). All other bytes are sent unchanged.
- FSM states:
  - POWERUP: count POWERUP_CYCLES, then go to INIT.
  - INIT: issue commands 0x38, 0x0C, 0x06, 0x01 in order, rs=0, then go to SNAP.
  - SNAP, one cycle: copy top/bottom into snapshot registers and go to ADDR_TOP.
  - ADDR_TOP: command 0x80.
  - WR_TOP: 16 data bytes, columns 0..15 from the snapshot.
  - ADDR_BOT: command 0xC0.
  - WR_BOT: 16 data bytes.
  - DONE, one cycle: frame_done=1, shadow <= snapshot, go to IDLE.
  - IDLE: busy=0. Go to SNAP in the same cycle that {top,bottom} != shadow is detected.
- After INIT, the first frame is always written, with no comparison.
- Inputs changing mid-frame are ignored, because the snapshot is used. Any difference from the shadow is caught in IDLE, so the next frame starts one cycle after DONE.
- busy is 1 in every state except IDLE; it drops the cycle after DONE.
- Column counter: 4 bits, 0..15. It must not wrap into a 17th write; reaching 15 with done advances the state.
- A zero-parameter value for a wait means no wait phase; `done` pulses on the last EN cycle.

Decomposition:
- Package lcd_pkg holds:
  - Command constants: LCD_FUNC_SET=8'h38, LCD_DISP_ON=8'h0C, LCD_ENTRY=8'h06, LCD_CLEAR=8'h01, LCD_ROW0=8'h80, LCD_ROW1=8'hC0, LCD_SPACE=8'h20.
  - The FSM state enum lcd_state_t.
- One sub-module, lcd_byte_strobe:
  - Inputs: start, rs, data, long_wait.
  - Outputs: lcd_en, lcd_rs, lcd_data, done.
  - Owns the EN/wait counter.

Test Plan (POWERUP_CYCLES=20, EN_CYCLES=2, WAIT_CYCLES=3, CLEAR_WAIT_CYCLES=10, so 6 cycles/byte and 13 for clear):
1. Reset release -> busy=1 and lcd_en=0 for 20 cycles. Then exactly 4 rs=0 strobes with data 38, 0C, 06, 01, each lcd_en pulse 2 cycles wide. The 01 transfer lasts 13 cycles.
2. top="  Win" padded, bottom="APPLE" padded with 8'h00 -> strobes in order: 80, 16 data bytes with 00 mapped to 20, C0, 16 bytes. frame_done pulses once, 204 cycles after SNAP. busy=0 next cycle.
3. Inputs held constant in IDLE for 1000 cycles -> no lcd_en activity; busy stays 0.
4. Change top column 3 only, to 8'h41 -> a full frame is rewritten, and column 3 data = 41.
5. Change bottom during WR_TOP -> current frame carries the old bottom. A second frame starts 1 cycle after frame_done and carries the new bottom.
6. Assert nRst during WR_BOT -> outputs return to reset values at once. After release the POWERUP wait of 20 cycles and INIT repeat before any data byte.
